mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Sequences one 8x8->32 MAC core (signed-8 a x unsigned-8 b product, accumulator that adds every
//  clock, synchronous clear) to compute one dot product per command.
//  Accepts a job length, clears the core, streams operand pairs into it, drains the multiply
//  pipeline, then returns the accumulator value on a valid/ready result port.
//  Sits between the matrix tile feeder and one MAC lane.
// PARAMETERS
//  LEN_W    16  width of cmd_len; max job = 2^LEN_W-1 beats
//  MUL_LAT  0   register stages inside the core multiplier (0 = combinational product)
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  cmd_valid  in   1      job request valid
//  cmd_ready  out  1      job accepted when cmd_valid & cmd_ready
//  cmd_len    in   LEN_W  number of operand pairs in the job (0 allowed)
//  op_valid   in   1      operand pair valid
//  op_ready   out  1      operand pair consumed when op_valid & op_ready
//  op_a       in   8      operand a (signed, passed untouched)
//  op_b       in   8      operand b (unsigned, passed untouched)
//  mac_clr    out  1      to core synchronous clear
//  mac_a      out  8      to core a_i (registered)
//  mac_b      out  8      to core b_i (registered)
//  mac_acc    in   32     from core accumulator output
//  res_valid  out  1      result valid
//  res_ready  in   1      result consumed when res_valid & res_ready
//  res_data   out  32     dot-product result
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset
//  - rst puts the FSM in IDLE and zeroes the beat counter, drain counter, mac_a, mac_b and res_data.
//  - While rst is high: cmd_ready=0, op_ready=0, res_valid=0, busy=0, mac_clr=1.
//  - rst mid-job abandons the job; no partial result is ever emitted.
//  Zero-operand rule
//  - The core adds every clock, so mac_a/mac_b are registered 0 on every cycle without an operand handshake.
//  - This covers IDLE, CLEAR, DRAIN, DONE and STREAM bubbles; the accumulator never drifts.
//  FSM states and transitions (mac_clr = rst | (state==CLEAR))
//  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_len into len_q and go to CLEAR.
//  - CLEAR (1 cycle): mac_clr=1, beat counter := 0. Next state is STREAM, or DRAIN if len_q==0.
//  - STREAM: op_ready=1.
//    - On handshake, mac_a<=op_a, mac_b<=op_b and the beat counter increments.
//    - The handshake with counter==len_q-1 moves to DRAIN; no further ops are accepted.
//  - DRAIN: lasts exactly 2+MUL_LAT cycles, op_ready=0.
//    - On the last DRAIN cycle, res_data<=mac_acc, then go to DONE.
//    - Why 2+MUL_LAT: operand register (1) + MUL_LAT + accumulator register (1).
//  - DONE: res_valid=1 and res_data held stable. On res_ready go to IDLE; cmd_ready rises the following cycle.
//  Latency
//  - Back-to-back job with no stalls: cmd accept -> res_valid takes 1 + len + 2+MUL_LAT + 1 cycles.
//  - Example: len=4, MUL_LAT=0 -> res_valid is first high 8 cycles after the cmd handshake cycle.
//  Arithmetic
//  - res_data is a bit-exact copy of mac_acc; wrap mod 2^32; no saturation.
//  - Overflow is impossible for len < 2^16 with the 8x8 product range.
//  Boundaries
//  - len=0: CLEAR->DRAIN, result 0.
//  - op_valid gaps: the beat counter holds and zero operands are driven.
//  - res_ready low: DONE holds indefinitely.
//  - cmd_valid while busy: ignored (cmd_ready=0).
//  - op_valid outside STREAM: ignored (op_ready=0).
// TESTING
//  1. len=4; a={1,2,3,4}, b={5,6,7,8} back-to-back; res_ready=1
//     -> res_data=70, res_valid exactly 8 cycles after cmd handshake (MUL_LAT=0).
//  2. len=0 -> res_data=0; mac_clr pulses once; no op_ready.
//  3. len=3 with a=127, b=255; op_valid low 2 cycles between beats
//     -> res_data=97155; mac_a/mac_b=0 during gaps.
//  4. Job1 len=2 (a=10,b=10 twice) with res_ready low 5 cycles
//     -> res_data=200 held stable, then job2 len=1 (a=3,b=9) -> 27 (no residue).
//  5. rst asserted mid-STREAM of a len=8 job, then job len=1 (a=2,b=2)
//     -> no result for aborted job; new result=4.
//  6. MUL_LAT=2 build, case 1 stimulus -> res_data=70, res_valid 10 cycles after cmd handshake.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Drives one signed-8 x unsigned-8 MAC lane through one dot-product job per command:
// clear, stream operand pairs, drain the multiply pipeline, then return the accumulator value.
module mac_dot_sequencer #(
    parameter int LEN_W   = 16,
    parameter int MUL_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    output logic             mac_clr,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic [31:0]      mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             busy
);

    // Operand register, MUL_LAT product stages and accumulator register all lie between
    // the last handshake and a settled mac_acc.
    localparam int DRAIN_CYC = MUL_LAT + 2;
    localparam int DRN_W     = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic [7:0]         mac_a_q, mac_a_d;
    logic [7:0]         mac_b_q, mac_b_d;
    logic [31:0]        res_data_q, res_data_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= {LEN_W{1'b0}};
            beat_q     <= {LEN_W{1'b0}};
            drain_q    <= {DRN_W{1'b0}};
            mac_a_q    <= 8'd0;
            mac_b_q    <= 8'd0;
            res_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            drain_q    <= drain_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            res_data_q <= res_data_d;
        end
    end

    // Next-state and datapath update; operands default to zero so the free-running
    // accumulator only ever sees real beats.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        mac_a_d    = 8'd0;
        mac_b_d    = 8'd0;
        res_data_d = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d   = cmd_len;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                beat_d  = {LEN_W{1'b0}};
                drain_d = {DRN_W{1'b0}};
                if (len_q == {LEN_W{1'b0}}) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (op_valid) begin
                    mac_a_d = op_a;
                    mac_b_d = op_b;
                    beat_d  = beat_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    if (beat_q == len_q - {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
                    res_data_d = mac_acc;
                    drain_d    = {DRN_W{1'b0}};
                    state_d    = S_DONE;
                end else begin
                    drain_d = drain_q + {{(DRN_W-1){1'b0}}, 1'b1};
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake strobes are forced inactive in the reset cycle itself, before the state register clears.
    assign cmd_ready = !rst && (state_q == S_IDLE);
    assign op_ready  = !rst && (state_q == S_STREAM);
    assign res_valid = !rst && (state_q == S_DONE);
    assign busy      = !rst && (state_q != S_IDLE);
    assign mac_clr   = rst || (state_q == S_CLEAR);
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: two lanes (MUL_LAT=0 and MUL_LAT=2), each with a MAC core model,
// with expected results queued when a job is driven and checked on the result handshake.
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        lane_sel;
    logic        cmd_valid;
    logic [15:0] cmd_len;
    logic        op_valid;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        res_ready;

    logic        cmd_ready0, op_ready0, mac_clr0, res_valid0, busy0;
    logic [7:0]  mac_a0, mac_b0;
    logic [31:0] mac_acc0, res_data0;
    logic        cmd_ready2, op_ready2, mac_clr2, res_valid2, busy2;
    logic [7:0]  mac_a2, mac_b2;
    logic [31:0] mac_acc2, res_data2, p1_2, p2_2;

    logic        cmd_ready, op_ready, mac_clr, res_valid, busy;
    logic [7:0]  mac_a, mac_b;
    logic [31:0] res_data;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          clr_cnt = 0;
    int          opr_cnt = 0;
    int          exp_sum = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mac_dot_sequencer #(.LEN_W(16), .MUL_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid & ~lane_sel), .cmd_ready(cmd_ready0), .cmd_len(cmd_len),
        .op_valid(op_valid & ~lane_sel), .op_ready(op_ready0), .op_a(op_a), .op_b(op_b),
        .mac_clr(mac_clr0), .mac_a(mac_a0), .mac_b(mac_b0), .mac_acc(mac_acc0),
        .res_valid(res_valid0), .res_ready(res_ready & ~lane_sel), .res_data(res_data0),
        .busy(busy0)
    );

    mac_dot_sequencer #(.LEN_W(16), .MUL_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid & lane_sel), .cmd_ready(cmd_ready2), .cmd_len(cmd_len),
        .op_valid(op_valid & lane_sel), .op_ready(op_ready2), .op_a(op_a), .op_b(op_b),
        .mac_clr(mac_clr2), .mac_a(mac_a2), .mac_b(mac_b2), .mac_acc(mac_acc2),
        .res_valid(res_valid2), .res_ready(res_ready & lane_sel), .res_data(res_data2),
        .busy(busy2)
    );

    function automatic logic [31:0] prod(input logic [7:0] a, input logic [7:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        sa   = {{24{a[7]}}, a};
        sb_v = {24'd0, b};
        return sa * sb_v;
    endfunction

    // MAC core models: accumulate every clock, synchronous clear, 0 or 2 product stages.
    always @(posedge clk) begin
        mac_acc0 <= mac_clr0 ? 32'd0 : mac_acc0 + prod(mac_a0, mac_b0);
        p1_2     <= rst ? 32'd0 : prod(mac_a2, mac_b2);
        p2_2     <= rst ? 32'd0 : p1_2;
        mac_acc2 <= mac_clr2 ? 32'd0 : mac_acc2 + p2_2;
    end

    assign cmd_ready = lane_sel ? cmd_ready2 : cmd_ready0;
    assign op_ready  = lane_sel ? op_ready2  : op_ready0;
    assign mac_clr   = lane_sel ? mac_clr2   : mac_clr0;
    assign res_valid = lane_sel ? res_valid2 : res_valid0;
    assign busy      = lane_sel ? busy2      : busy0;
    assign mac_a     = lane_sel ? mac_a2     : mac_a0;
    assign mac_b     = lane_sel ? mac_b2     : mac_b0;
    assign res_data  = lane_sel ? res_data2  : res_data0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Result monitor: any valid result must be pending in the scoreboard; pop on handshake.
    always @(negedge clk) begin
        if (mac_clr) clr_cnt++;
        if (op_ready) opr_cnt++;
        if (res_valid) begin
            chk("res_pending", 32'(sb.size() != 0), 32'd1);
            if (res_ready && sb.size() != 0) chk("res_data", res_data, sb.pop_front());
        end
    end

    task automatic do_cmd(input int len);
        int got;
        cmd_valid = 1'b1;
        cmd_len   = 16'(len);
        got       = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1;
        end
        chk("cmd_accept_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        hs_cyc    = cyc;
        cmd_valid = 1'b0;
        exp_sum   = 0;
    endtask

    task automatic send_op(input int a, input int b);
        int got;
        op_valid = 1'b1;
        op_a     = a[7:0];
        op_b     = b[7:0];
        got      = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            @(negedge clk);
            if (op_ready) got = 1;
        end
        chk("op_accept_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        exp_sum  = exp_sum + a * b;
    endtask

    task automatic wait_res(input string tag, input int exp_lat);
        int got;
        got = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            @(negedge clk);
            if (res_valid) got = 1;
        end
        chk({tag, "_res_timeout"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - hs_cyc + 1), 32'(exp_lat));
    endtask

    initial begin
        rst = 1'b1; lane_sel = 1'b0; cmd_valid = 1'b0; cmd_len = 16'd0;
        op_valid = 1'b0; op_a = 8'd0; op_b = 8'd0; res_ready = 1'b0;

        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mac_clr", 32'(mac_clr), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_mac_clr", 32'(mac_clr), 32'd0);
        chk("idle_mac_a", 32'(mac_a), 32'd0);
        chk("idle_res_data", res_data, 32'd0);
        @(posedge clk); #1;

        // 1: len=4 back-to-back -> 70, latency 8
        res_ready = 1'b1;
        do_cmd(4);
        send_op(1, 5); send_op(2, 6); send_op(3, 7); send_op(4, 8);
        sb.push_back(32'(exp_sum));
        wait_res("t1", 8);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 2: len=0 -> 0, one clear pulse, no op_ready even with op_valid high
        clr_cnt = 0; opr_cnt = 0;
        op_valid = 1'b1; op_a = 8'd9; op_b = 8'd9;
        do_cmd(0);
        sb.push_back(32'd0);
        wait_res("t2", 4);
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("t2_clr_pulses", 32'(clr_cnt), 32'd1);
        chk("t2_op_ready_cnt", 32'(opr_cnt), 32'd0);

        // 3: len=3, 127*255 with two-cycle gaps -> 97155
        do_cmd(3);
        for (int k = 0; k < 3; k++) begin
            send_op(127, 255);
            if (k < 2) begin
                @(negedge clk);
                chk("t3_mac_a_beat", 32'(mac_a), 32'd127);
                chk("t3_mac_b_beat", 32'(mac_b), 32'd255);
                @(negedge clk);
                chk("t3_mac_a_gap", 32'(mac_a), 32'd0);
                chk("t3_mac_b_gap", 32'(mac_b), 32'd0);
                @(posedge clk); #1;
            end
        end
        sb.push_back(32'(exp_sum));
        wait_res("t3", 1 + 3 + 4 + 2 + 1);
        @(posedge clk); #1;

        // 4: result held while res_ready low, then a clean follow-on job
        res_ready = 1'b0;
        do_cmd(2);
        send_op(10, 10); send_op(10, 10);
        sb.push_back(32'(exp_sum));
        wait_res("t4a", 6);
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(res_valid), 32'd1);
            chk("t4_hold_data", res_data, 32'd200);
            chk("t4_hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        do_cmd(1);
        send_op(3, 9);
        sb.push_back(32'(exp_sum));
        wait_res("t4b", 5);
        @(posedge clk); #1;

        // 5: reset mid-stream abandons the job
        do_cmd(8);
        send_op(7, 7); send_op(7, 7); send_op(7, 7);
        op_valid = 1'b1; op_a = 8'd5; op_b = 8'd5;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_op_ready", 32'(op_ready), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_mac_clr", 32'(mac_clr), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("t5_no_result", 32'(res_valid), 32'd0);
        end
        @(posedge clk); #1;
        do_cmd(1);
        send_op(2, 2);
        sb.push_back(32'(exp_sum));
        wait_res("t5", 5);
        @(posedge clk); #1;

        // 6: MUL_LAT=2 lane, case 1 stimulus -> 70, latency 10
        lane_sel = 1'b1;
        do_cmd(4);
        send_op(1, 5); send_op(2, 6); send_op(3, 7); send_op(4, 8);
        sb.push_back(32'(exp_sum));
        wait_res("t6", 10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_cmd_ready_after", 32'(cmd_ready), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
